// File: rtl/seg7_pkg.sv
// Shared types and helpers for the scanned 7-segment display.
package seg7_pkg;

   // Display controller states.
   typedef enum logic [1:0] {
      StIdle,
      StConvert,
      StShow
   } state_e;

   // All segments off (active-low).
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // BCD nibble to active-low segment pattern, bit order gfedcba.
   // Non-decimal nibbles show nothing.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_dd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// start loads a new value; busy stays high for VALUE_W cycles. done is a
// combinational pulse on the cycle of the last iteration, and bcd then holds
// the final result (it is the value the BCD register takes at that edge).
module bcd_dd_converter #(
   parameter int unsigned VALUE_W    = 14,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [VALUE_W-1:0]      bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

   logic [VALUE_W-1:0] shift_q, shift_d, shift_step;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj, bcd_step;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;

   // One iteration: add 3 to every nibble >= 5, then shift {bcd, bin} left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_step   = {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
      shift_step = {shift_q[VALUE_W-2:0], 1'b0};
   end

   // Next-state: abort wins, then start, then iterate while busy.
   always_comb begin
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      if (abort) begin
         busy_d = 1'b0;
      end else if (start) begin
         busy_d  = 1'b1;
         shift_d = bin;
         bcd_d   = '0;
         cnt_d   = '0;
      end else if (busy_q) begin
         shift_d = shift_step;
         bcd_d   = bcd_step;
         cnt_d   = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   // Converter state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         shift_q <= '0;
         bcd_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
      end
   end

   assign busy = busy_q;
   assign done = busy_q & ~abort & (cnt_q == CNT_LAST);
   assign bcd  = bcd_step;

endmodule

// File: rtl/seg7_scan_display.sv
// Captures a value on the display_enable rising edge, converts it to BCD and
// scans it onto a multiplexed common-anode 7-segment display while enabled.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned VALUE_W      = 14,
   parameter int unsigned DIGIT_CYCLES = 50_000,
   parameter int unsigned BLANK_LZ     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  display_enable,
   input  logic [VALUE_W-1:0]    value,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  busy
);

   localparam int unsigned SAT_MAX = (10 ** NUM_DIGITS) - 1;
   localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
   localparam int unsigned SCAN_W  = $clog2(DIGIT_CYCLES);
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGIT_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   state_e state_q, state_d;

   logic                  en_hist_q;
   logic                  rise;
   logic [VALUE_W-1:0]    value_sat;
   logic                  conv_start, conv_abort, conv_busy, conv_done;
   logic [BCD_W-1:0]      conv_bcd;
   logic [BCD_W-1:0]      digits_q;
   logic [SCAN_W-1:0]     scan_q;
   logic [IDX_W-1:0]      idx_q;
   logic [3:0]            cur_nibble;
   logic                  upper_zero, blank_digit;
   logic [6:0]            seg_d, seg_q;
   logic [NUM_DIGITS-1:0] an_d, an_q;
   logic                  busy_q;

   assign rise = display_enable & ~en_hist_q;

   // Values that do not fit in NUM_DIGITS decimal digits show as all nines.
   assign value_sat = (32'(value) > SAT_MAX) ? VALUE_W'(SAT_MAX) : value;

   bcd_dd_converter #(
      .VALUE_W    (VALUE_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_conv (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .abort (conv_abort),
      .bin   (value_sat),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // FSM next-state and converter control; losing enable always wins.
   always_comb begin
      state_d    = state_q;
      conv_start = 1'b0;
      conv_abort = 1'b0;
      case (state_q)
         StIdle: begin
            if (rise) begin
               state_d    = StConvert;
               conv_start = 1'b1;
            end
         end
         StConvert: begin
            if (!display_enable) begin
               state_d    = StIdle;
               conv_abort = 1'b1;
            end else if (conv_done) begin
               state_d = StShow;
            end
         end
         StShow: begin
            if (!display_enable) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state, enable history and latched BCD digits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         en_hist_q <= 1'b0;
         digits_q  <= '0;
      end else begin
         state_q   <= state_d;
         en_hist_q <= display_enable;
         if (state_q == StConvert && state_d == StShow) begin
            digits_q <= conv_bcd;
         end
      end
   end

   // Scan timing; held at zero outside SHOW so digit 0 is shown first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_q <= '0;
         idx_q  <= '0;
      end else if (state_q != StShow) begin
         scan_q <= '0;
         idx_q  <= '0;
      end else if (scan_q == SCAN_LAST) begin
         scan_q <= '0;
         idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
         scan_q <= scan_q + SCAN_W'(1);
      end
   end

   // Select the current nibble and decide leading-zero blanking.
   always_comb begin
      cur_nibble = 4'd0;
      upper_zero = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j == int'(idx_q)) begin
            cur_nibble = digits_q[4*j +: 4];
         end
         if (j >= int'(idx_q) && digits_q[4*j +: 4] != 4'd0) begin
            upper_zero = 1'b0;
         end
      end
      blank_digit = (BLANK_LZ != 0) && upper_zero && (idx_q != '0);
   end

   // Next segment/anode pattern; blank unless showing a non-blanked digit.
   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = '1;
      if (state_q == StShow && !blank_digit) begin
         seg_d        = bcd_to_seg(cur_nibble);
         an_d[idx_q]  = 1'b0;
      end
   end

   // Registered pin drivers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q  <= SEG_BLANK;
         an_q   <= '1;
         busy_q <= 1'b0;
      end else begin
         seg_q  <= seg_d;
         an_q   <= an_d;
         busy_q <= conv_busy;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;
   assign dp   = 1'b1;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Consumer side of the display-enable interface. Latches the generated random value when `display_enable` rises.
- Converts the latched value to BCD with a sequential double-dabble converter.
- Drives a multiplexed common-anode 7-segment display for as long as `display_enable` stays high.
- Sits between the display timer / number generator and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits.
- VALUE_W, 14: width of the binary input value.
- DIGIT_CYCLES, 50_000: clk cycles each digit is lit (1 ms at 50 MHz); minimum 2.
- BLANK_LZ, 1: 1 = blank leading zeros (digit 0 is never blanked).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- display_enable  in  1  level; high = show the number
- value  in  VALUE_W  binary number to show; sampled only on the enable rising edge
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g
- dp  out  1  active-low decimal point; always 1 (off)
- an  out  NUM_DIGITS  active-low anodes; an[0] = ones digit
- busy  out  1  high while the BCD conversion is running

Behaviour:
- Reset (async, active-high) sets all outputs and state:
  - seg=all 1, an=all 1, dp=1, busy=0.
  - state=IDLE; scan counter=0, digit index=0; enable history register=0.
- Edge detect: en_d <= display_enable every cycle. rise = display_enable & ~en_d.
- Saturation: SAT_MAX = 10^NUM_DIGITS−1 (localparam). Captured value = min(value, SAT_MAX).
- State IDLE:
  - Outputs blank (an all 1, seg all 1).
  - On rise: load the shift register with the captured value, clear the BCD register, set bit counter=0, go to CONVERT.
- State CONVERT:
  - One double-dabble iteration per cycle: add 3 to each BCD nibble ≥5, then shift left 1.
  - Exactly VALUE_W cycles, then go to SHOW with the BCD result latched into the digit register.
  - busy=1 for exactly these VALUE_W cycles. Display is blank.
- State SHOW:
  - Scan counter counts 0..DIGIT_CYCLES−1. On wrap, digit index advances and wraps NUM_DIGITS−1 → 0.
  - Scan counter and digit index reset to 0 on entry to SHOW, so digit 0 is shown first.
  - an = one-hot-low of the digit index. seg = decode of that BCD nibble.
  - Blanked digit: BLANK_LZ=1 and the digit and all higher digits are 0 and index ≠ 0. Its anode is deasserted (all 1) and seg = all 1.
- Output registration: seg, an and busy are registered, so they follow the state/index by one cycle.
- Latency: rise sampled at cycle N → busy high in cycles N+1 … N+VALUE_W → first lit digit in cycle N+VALUE_W+1.
- display_enable low in CONVERT or SHOW:
  - Go to IDLE at the next edge; outputs blank the following cycle; busy=0.
  - Any partial conversion is discarded.
- Rise in the same cycle the FSM returns to IDLE cannot occur, because rise needs en_d=0.
- Rise while in IDLE always recaptures `value`. Holding enable high never recaptures.
- Changes on `value` outside a rising edge are ignored.
- Decode table (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - Nibbles >9 cannot occur after saturation; map them to all 1.

Decomposition:
- Package seg7_pkg holds:
  - the state enum (IDLE, CONVERT, SHOW);
  - the decode function bcd_to_seg (nibble → 7-bit active-low);
  - the SEG_BLANK constant (7'h7F).
- One sub-module, bcd_dd_converter: sequential double-dabble with start/busy/done and parameters VALUE_W, NUM_DIGITS.
- The top module keeps the FSM, scan counter, blanking logic and output registers.

Test Plan (DIGIT_CYCLES=4, VALUE_W=14, NUM_DIGITS=4, BLANK_LZ=1):
1. Assert reset mid-SHOW, async → an=4'hF, seg=7'h7F, dp=1 and busy=0 immediately. Without a fresh enable rise after release, outputs stay blank.
2. value=1234, enable rises → busy high exactly 14 cycles. Then, every 4 clocks:
   - an=E with seg=19
   - an=D with seg=30
   - an=B with seg=24
   - an=7 with seg=79
   - the sequence then repeats.
3. value=7 → only an=E is lit (seg=78); the other 3 slots show an=F, seg=7F. value=0 → an=E with seg=40.
4. value=16383 → saturates to 9999; all four digits show seg=10.
5. Drop enable 5 cycles into CONVERT → blank and busy=0 within 2 cycles. Re-raise with value=42 → shows 42, not the old value.
6. Change value from 1234 to 5678 while SHOW is active with enable held high → display stays 1234. Enable low, then high again → shows 5678 after 14 busy cycles.
